// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding and FSM states.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add for multiply, restoring
// subtract-and-shift for divide, both through a single WIDTH+1-bit adder.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   base;
    logic [WIDTH:0]   addend;
    logic [WIDTH+1:0] result;
    logic             fits;

    always_comb begin
        // Divide subtracts via invert-plus-carry; carry out means no borrow.
        base    = div ? {hi, lo[WIDTH-1]} : {1'b0, hi};
        addend  = div ? ~{1'b0, operand} : {1'b0, operand};
        result  = {1'b0, base} + {1'b0, addend} + {{(WIDTH+1){1'b0}}, div};
        fits    = result[WIDTH+1];
        hi_next = hi;
        lo_next = lo;
        if (div) begin
            hi_next = fits ? result[WIDTH-1:0] : base[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end else if (lo[0]) begin
            hi_next = result[WIDTH:1];
            lo_next = {result[0], lo[WIDTH-1:1]};
        end else begin
            hi_next = {1'b0, hi[WIDTH-1:1]};
            lo_next = {hi[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_param.sv
// Iterative signed/unsigned multiplier and divider: one bit per cycle on
// operand magnitudes, with two's-complement sign fix-up at the end.
module muldiv_param
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] high,
    output logic [WIDTH-1:0] low,
    output logic             div_zero,
    output logic [2:0]       state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int W2    = 2 * WIDTH;

    logic [WIDTH-1:0] a_r, b_r, m_r, p_r, q_r;
    logic [1:0]       op_r;
    logic             neg_res, neg_rem;
    logic [CNT_W-1:0] cnt;

    logic             signed_op, a_neg, b_neg, is_div;
    logic [WIDTH-1:0] a_mag, b_mag, p_next, q_next;
    logic [WIDTH-1:0] high_fix, low_fix;
    logic [W2-1:0]    prod;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_comb begin
        is_div    = op_is_div(op_r);
        signed_op = (SIGNED_EN != 0) && !op_r[0];
        a_neg     = signed_op && a_r[WIDTH-1];
        b_neg     = signed_op && b_r[WIDTH-1];
        a_mag     = a_neg ? (~a_r + WIDTH'(1)) : a_r;
        b_mag     = b_neg ? (~b_r + WIDTH'(1)) : b_r;
        prod      = neg_res ? (~{p_r, q_r} + W2'(1)) : {p_r, q_r};
        // Quotient follows the sign of the operand XOR; remainder follows the dividend.
        if (is_div) begin
            low_fix  = neg_res ? (~q_r + WIDTH'(1)) : q_r;
            high_fix = neg_rem ? (~p_r + WIDTH'(1)) : p_r;
        end else begin
            low_fix  = prod[WIDTH-1:0];
            high_fix = prod[W2-1:WIDTH];
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div     (is_div),
        .hi      (p_r),
        .lo      (q_r),
        .operand (m_r),
        .hi_next (p_next),
        .lo_next (q_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            m_r      <= '0;
            p_r      <= '0;
            q_r      <= '0;
            op_r     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            cnt      <= '0;
            high     <= '0;
            low      <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        op_r     <= op;
                        div_zero <= 1'b0;
                        state    <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    cnt     <= '0;
                    p_r     <= '0;
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    if (is_div) begin
                        q_r <= a_mag;
                        m_r <= b_mag;
                    end else begin
                        q_r <= b_mag;
                        m_r <= a_mag;
                    end
                    // Zero divisor skips RUN but still passes FIX, which leaves high/low alone.
                    if (is_div && (b_r == '0)) begin
                        div_zero <= 1'b1;
                        state    <= ST_FIX;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    p_r <= p_next;
                    q_r <= q_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (!div_zero) begin
                        high <= high_fix;
                        low  <= low_fix;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_param.sv
// Bench for muldiv_param: WIDTH=32 and WIDTH=8 instances against a wide-integer reference model.
module tb_muldiv_param;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start32 = 1'b0;
    logic [1:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, dz32;
    logic [31:0] high32, low32;
    logic [2:0]  state32;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  high8, low8;
    logic [2:0]  state8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_param #(.WIDTH(32), .SIGNED_EN(1)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .high(high32), .low(low32),
        .div_zero(dz32), .state(state32)
    );

    muldiv_param #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .high(high8), .low(low8),
        .div_zero(dz8), .state(state8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide-integer arithmetic on the operands interpreted per op.
    function automatic void model(input int w, input logic [1:0] o, input logic [31:0] x, y,
                                  input logic [31:0] ph, pl,
                                  output logic [31:0] eh, el, output logic edz, output int elat);
        logic [127:0]        mask;
        logic signed [127:0] sx, sy, r, q;
        mask = (128'd1 << w) - 128'd1;
        sx = $signed({96'b0, x}) & mask;
        sy = $signed({96'b0, y}) & mask;
        if (!o[0] && sx[w-1]) sx = sx - (128'sd1 <<< w);
        if (!o[0] && sy[w-1]) sy = sy - (128'sd1 <<< w);
        if (!o[1]) begin
            r = sx * sy;
            el = 32'(r & mask);
            eh = 32'((r >> w) & mask);
            edz = 1'b0;
            elat = w + 2;
        end else if (sy == 0) begin
            eh = ph;
            el = pl;
            edz = 1'b1;
            elat = 2;
        end else begin
            q = sx / sy;
            r = sx % sy;
            el = 32'(q & mask);
            eh = 32'(r & mask);
            edz = 1'b0;
            elat = w + 2;
        end
    endfunction

    // Launches one op, scrambles inputs while busy, optionally re-pulses start,
    // and returns the result with the edge index after which done was seen.
    task automatic run_op(input bit w8, input logic [1:0] o, input logic [31:0] x, y,
                          input int pulse_edge,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz, output int lat);
        @(negedge clk);
        if (w8) begin op8 = o; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
        else    begin op32 = o; a32 = x; b32 = y; start32 = 1'b1; end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start32 = 1'b0;
        op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
        check("busy_after_start", w8 ? busy8 : busy32, 1);
        lat = -1;
        hi = '0; lo = '0; dz = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == pulse_edge) begin
                if (w8) start8 = 1'b1; else start32 = 1'b1;
            end
            @(posedge clk);
            #1;
            start8 = 1'b0;
            start32 = 1'b0;
            if (w8 ? done8 : done32) begin
                lat = n;
                hi = w8 ? {24'b0, high8} : high32;
                lo = w8 ? {24'b0, low8} : low32;
                dz = w8 ? dz8 : dz32;
                break;
            end
        end
        @(posedge clk);
        #1;
        check("done_one_pulse", w8 ? done8 : done32, 0);
    endtask

    logic [31:0] hi, lo, eh, el, prev_hi32, prev_lo32, prev_hi8, prev_lo8;
    logic        dz, edz;
    int          lat, elat;
    logic [1:0]  o;
    logic [31:0] x, y;

    initial begin
        prev_hi32 = '0; prev_lo32 = '0; prev_hi8 = '0; prev_lo8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy32", busy32, 0);
        check("rst_done32", done32, 0);
        check("rst_high32", high32, 0);
        check("rst_low32", low32, 0);
        check("rst_dz32", dz32, 0);
        check("rst_high8", high8, 0);
        check("rst_low8", low8, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(0, OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, hi, lo, dz, lat);
        check("mult_high", hi, 32'hFFFF_FFFF);
        check("mult_low", lo, 32'hFFFF_FFF1);
        check("mult_lat", lat, 34);
        check("mult_dz", dz, 0);

        run_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, hi, lo, dz, lat);
        check("multu_high", hi, 32'hFFFF_FFFE);
        check("multu_low", lo, 32'h0000_0001);

        run_op(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, hi, lo, dz, lat);
        check("div_low", lo, 32'hFFFF_FFFD);
        check("div_high", hi, 32'hFFFF_FFFF);
        check("div_lat", lat, 34);

        run_op(0, OP_DIVU, 32'd7, 32'd2, 0, hi, lo, dz, lat);
        check("divu_low", lo, 32'd3);
        check("divu_high", hi, 32'd1);

        run_op(0, OP_DIVU, 32'd100, 32'd0, 0, hi, lo, dz, lat);
        check("dz_flag", dz, 1);
        check("dz_lat", lat, 2);
        check("dz_high_held", hi, 32'd1);
        check("dz_low_held", lo, 32'd3);

        // A second start mid-operation must not disturb or queue anything.
        run_op(0, OP_MULTU, 32'h1234_5678, 32'd9, 10, hi, lo, dz, lat);
        model(32, OP_MULTU, 32'h1234_5678, 32'd9, 0, 0, eh, el, edz, elat);
        check("ignored_start_high", hi, eh);
        check("ignored_start_low", lo, el);
        check("ignored_start_lat", lat, 34);
        repeat (3) @(posedge clk);
        #1;
        check("no_queued_op", busy32, 0);

        @(negedge clk);
        op32 = OP_MULT; a32 = 32'd1000; b32 = 32'd1000; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", busy32, 0);
        check("midrst_done", done32, 0);
        check("midrst_high", high32, 0);
        check("midrst_low", low32, 0);
        check("midrst_dz", dz32, 0);
        check("midrst_state", state32, ST_IDLE);
        @(negedge clk);
        reset = 1'b0;
        prev_hi32 = '0; prev_lo32 = '0; prev_hi8 = '0; prev_lo8 = '0;

        run_op(0, OP_MULT, 32'd6, 32'd7, 0, hi, lo, dz, lat);
        check("post_rst_low", lo, 32'd42);
        check("post_rst_high", hi, 32'd0);
        prev_hi32 = hi; prev_lo32 = lo;

        run_op(1, OP_DIV, 32'h80, 32'hFF, 0, hi, lo, dz, lat);
        check("w8_minneg1_low", lo, 32'h80);
        check("w8_minneg1_high", hi, 32'h00);
        check("w8_minneg1_dz", dz, 0);
        check("w8_minneg1_lat", lat, 10);
        prev_hi8 = hi; prev_lo8 = lo;

        for (int i = 0; i < 50; i++) begin
            bit w8;
            int w;
            w8 = (i >= 30);
            w = w8 ? 8 : 32;
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 5);
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) x = w8 ? 32'h80 : 32'h8000_0000;
            if (w8) begin x = x & 32'hFF; y = y & 32'hFF; end
            run_op(w8, o, x, y, 0, hi, lo, dz, lat);
            if (w8) model(w, o, x, y, prev_hi8, prev_lo8, eh, el, edz, elat);
            else    model(w, o, x, y, prev_hi32, prev_lo32, eh, el, edz, elat);
            check($sformatf("rand%0d_high op=%0d a=%0h b=%0h", i, o, x, y), hi, eh);
            check($sformatf("rand%0d_low op=%0d a=%0h b=%0h", i, o, x, y), lo, el);
            check($sformatf("rand%0d_dz", i), dz, edz);
            check($sformatf("rand%0d_lat", i), lat, elat);
            if (w8) begin prev_hi8 = eh; prev_lo8 = el; end
            else    begin prev_hi32 = eh; prev_lo32 = el; end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
